osd_row_writer: RTL

- Avalon-MM master that sequences OSD text updates into the OSD generator's slave register map (char array words 0x00-0xEF, row-enable regs 0xF1/0xF2, row-colour reg 0xF3).
- Accepts row-level commands plus a character byte stream, packs characters four per word and issues the char-array writes.
- Maintains shadow copies of the enable and colour registers and writes them back as full words, so no read-modify-write is needed.
- Sits between the system CPU/menu logic and the OSD generator slave, in the clk_i domain.

---
 rtl/osd_row_writer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/osd_row_writer.sv
// Avalon-MM master that packs OSD row text into the generator's char array and keeps enable/colour shadows.
// Optional build macro OSD_ROW_WRITER_CLEAR_CHARS_EN: CLEAR_ROW also zeroes the row's four char words.
module osd_row_writer #(
  parameter int CHAR_ROWS = 30,
  parameter int CHAR_COLS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_row,
  input  logic        cmd_sec,
  input  logic        cmd_hilite,
  input  logic        chr_valid,
  output logic        chr_ready,
  input  logic [7:0]  chr_data,
  output logic [7:0]  avalon_m_address,
  output logic [31:0] avalon_m_writedata,
  output logic [3:0]  avalon_m_byteenable,
  output logic        avalon_m_write,
  input  logic        avalon_m_waitrequest_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] LAST_WORD = 2'(CHAR_COLS / 4 - 1);
  localparam logic [7:0] ADDR_LSEC = 8'hF1;
  localparam logic [7:0] ADDR_RSEC = 8'hF2;
  localparam logic [7:0] ADDR_COL  = 8'hF3;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WR_CHAR, S_WR_EN, S_WR_COL, S_CLR_F1, S_CLR_F2, S_CLR_F3
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE_ROW, OP_CLEAR_ROW, OP_CLEAR_ALL, OP_RSVD
  } op_t;

  state_t               state;
  op_t                  op_q;
  logic [4:0]           row_q;
  logic                 sec_q;
  logic                 hil_q;
  logic [1:0]           bcnt_q;
  logic [1:0]           word_q;
  logic [3:0][7:0]      byte_buf;
  logic [CHAR_ROWS-1:0] lsec_shadow;
  logic [CHAR_ROWS-1:0] rsec_shadow;
  logic [CHAR_ROWS-1:0] colour_shadow;

  logic [4:0]           en_row;
  logic                 en_sec;
  logic                 en_on;
  logic [CHAR_ROWS-1:0] en_bit;
  logic [CHAR_ROWS-1:0] col_bit;
  logic [CHAR_ROWS-1:0] lsec_nx;
  logic [CHAR_ROWS-1:0] rsec_nx;
  logic [CHAR_ROWS-1:0] col_nx;

  assign cmd_ready           = (state == S_IDLE);
  assign busy                = (state != S_IDLE);
  assign chr_ready           = (state == S_COLLECT);
  assign avalon_m_byteenable = 4'hF;

  // The enable update is shared by the IDLE path (plain CLEAR_ROW) and the post-char path.
  always_comb begin
    en_row  = (state == S_IDLE) ? cmd_row : row_q;
    en_sec  = (state == S_IDLE) ? cmd_sec : sec_q;
    en_on   = (state != S_IDLE) && (op_q == OP_WRITE_ROW);
    en_bit  = CHAR_ROWS'(1) << en_row;
    col_bit = CHAR_ROWS'(1) << row_q;
    lsec_nx = en_on ? (lsec_shadow | en_bit) : (lsec_shadow & ~en_bit);
    rsec_nx = en_on ? (rsec_shadow | en_bit) : (rsec_shadow & ~en_bit);
    col_nx  = hil_q ? (colour_shadow | col_bit) : (colour_shadow & ~col_bit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state              <= S_IDLE;
      op_q               <= OP_WRITE_ROW;
      row_q              <= '0;
      sec_q              <= 1'b0;
      hil_q              <= 1'b0;
      bcnt_q             <= '0;
      word_q             <= '0;
      byte_buf           <= '0;
      lsec_shadow        <= '0;
      rsec_shadow        <= '0;
      colour_shadow      <= '0;
      avalon_m_address   <= '0;
      avalon_m_writedata <= '0;
      avalon_m_write     <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_t'(cmd_op);
            row_q  <= cmd_row;
            sec_q  <= cmd_sec;
            hil_q  <= cmd_hilite;
            bcnt_q <= '0;
            word_q <= '0;
            if (op_t'(cmd_op) == OP_RSVD || int'(cmd_row) >= CHAR_ROWS) begin
              err <= 1'b1;
            end else begin
              case (op_t'(cmd_op))
                OP_WRITE_ROW: state <= S_COLLECT;
                OP_CLEAR_ROW: begin
`ifdef OSD_ROW_WRITER_CLEAR_CHARS_EN
                  state              <= S_WR_CHAR;
                  avalon_m_write     <= 1'b1;
                  avalon_m_address   <= {cmd_row, cmd_sec, 2'd0};
                  avalon_m_writedata <= '0;
`else
                  state          <= S_WR_EN;
                  avalon_m_write <= 1'b1;
                  if (en_sec) begin
                    rsec_shadow        <= rsec_nx;
                    avalon_m_address   <= ADDR_RSEC;
                    avalon_m_writedata <= 32'(rsec_nx);
                  end else begin
                    lsec_shadow        <= lsec_nx;
                    avalon_m_address   <= ADDR_LSEC;
                    avalon_m_writedata <= 32'(lsec_nx);
                  end
`endif
                end
                default: begin
                  state              <= S_CLR_F1;
                  lsec_shadow        <= '0;
                  rsec_shadow        <= '0;
                  colour_shadow      <= '0;
                  avalon_m_write     <= 1'b1;
                  avalon_m_address   <= ADDR_LSEC;
                  avalon_m_writedata <= '0;
                end
              endcase
            end
          end
        end
        S_COLLECT: begin
          if (chr_valid) begin
            byte_buf[bcnt_q] <= chr_data;
            bcnt_q           <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state              <= S_WR_CHAR;
              avalon_m_write     <= 1'b1;
              avalon_m_address   <= {row_q, sec_q, word_q};
              avalon_m_writedata <= {chr_data, byte_buf[2:0]};
            end
          end
        end
        S_WR_CHAR: begin
          if (avalon_m_waitrequest_n) begin
            if (word_q == LAST_WORD) begin
              state          <= S_WR_EN;
              avalon_m_write <= 1'b1;
              if (sec_q) begin
                rsec_shadow        <= rsec_nx;
                avalon_m_address   <= ADDR_RSEC;
                avalon_m_writedata <= 32'(rsec_nx);
              end else begin
                lsec_shadow        <= lsec_nx;
                avalon_m_address   <= ADDR_LSEC;
                avalon_m_writedata <= 32'(lsec_nx);
              end
            end else if (op_q == OP_WRITE_ROW) begin
              word_q             <= word_q + 2'd1;
              state              <= S_COLLECT;
              avalon_m_write     <= 1'b0;
              avalon_m_address   <= '0;
              avalon_m_writedata <= '0;
            end else begin
              word_q             <= word_q + 2'd1;
              avalon_m_address   <= {row_q, sec_q, 2'(word_q + 2'd1)};
              avalon_m_writedata <= '0;
            end
          end
        end
        S_WR_EN: begin
          if (avalon_m_waitrequest_n) begin
            if (op_q == OP_WRITE_ROW) begin
              state              <= S_WR_COL;
              colour_shadow      <= col_nx;
              avalon_m_address   <= ADDR_COL;
              avalon_m_writedata <= 32'(col_nx);
            end else begin
              state              <= S_IDLE;
              done               <= 1'b1;
              avalon_m_write     <= 1'b0;
              avalon_m_address   <= '0;
              avalon_m_writedata <= '0;
            end
          end
        end
        S_CLR_F1: begin
          if (avalon_m_waitrequest_n) begin
            state            <= S_CLR_F2;
            avalon_m_address <= ADDR_RSEC;
          end
        end
        S_CLR_F2: begin
          if (avalon_m_waitrequest_n) begin
            state            <= S_CLR_F3;
            avalon_m_address <= ADDR_COL;
          end
        end
        default: begin
          if (avalon_m_waitrequest_n) begin
            state              <= S_IDLE;
            done               <= 1'b1;
            avalon_m_write     <= 1'b0;
            avalon_m_address   <= '0;
            avalon_m_writedata <= '0;
          end
        end
      endcase
    end
  end

endmodule
